// File: rtl/sub_pkg.sv
// Shared types and the borrow dot-cell operator for the pipelined subtractor.
// Saturating build is selected with SUB_SATURATE_EN (see sub_pipe).
package sub_pkg;

    localparam int unsigned SUB_W_DEFAULT = 6;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t dot(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/sub_pipe_borrow_prefix.sv
// Combinational Ladner-Fischer borrow network: b[i] = G[i:0] over ceil(log2(W)) dot-cell levels.
// Each level merges a node with the top node of the lower half of its aligned block.
module borrow_prefix
    import sub_pkg::*;
#(
    parameter int unsigned W = SUB_W_DEFAULT
) (
    input  logic [W-1:0] g,
    input  logic [W-1:0] p,
    output logic [W-1:0] b
);

    localparam int unsigned LEVELS = (W > 1) ? $clog2(W) : 1;

    always_comb begin : prefix
        gp_t cur [W];
        gp_t nxt [W];
        for (int unsigned i = 0; i < W; i++) begin
            cur[i].g = g[i];
            cur[i].p = p[i];
        end
        for (int unsigned l = 0; l < LEVELS; l++) begin
            nxt = cur;
            for (int unsigned i = 0; i < W; i++) begin
                // bit l set: combine with the last node of the lower 2^l half of the block
                if (((i >> l) & 1) == 1)
                    nxt[i] = dot(cur[i], cur[((i >> l) << l) - 1]);
            end
            cur = nxt;
        end
        for (int unsigned i = 0; i < W; i++)
            b[i] = cur[i].g;
    end

endmodule

// File: rtl/sub_pipe.sv
// Two-stage valid/ready pipelined unsigned subtractor d = x - y, bo = (x < y).
// Define SUB_SATURATE_EN to clamp d to zero whenever a borrow-out occurs.
module sub_pipe
    import sub_pkg::*;
#(
    parameter int unsigned W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bo
);

    logic         s1_valid;
    logic [W-1:0] s1_g;
    logic [W-1:0] s1_p;
    logic [W-1:0] s1_h;
    logic         s2_adv;
    logic         in_fire;
    logic [W-1:0] b;
    logic [W-1:0] d_raw;
    logic [W-1:0] d_nxt;

    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign in_fire  = in_valid & in_ready;

    borrow_prefix #(.W(W)) u_borrow_prefix (
        .g (s1_g),
        .p (s1_p),
        .b (b)
    );

    always_comb begin
        d_raw = s1_h ^ {b[W-2:0], 1'b0};
`ifdef SUB_SATURATE_EN
        d_nxt = b[W-1] ? '0 : d_raw;
`else
        d_nxt = d_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_g      <= '0;
            s1_p      <= '0;
            s1_h      <= '0;
            out_valid <= 1'b0;
            d         <= '0;
            bo        <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_g <= ~x & y;
                s1_p <= ~(x ^ y);
                s1_h <= x ^ y;
            end

            if (in_fire)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;

            // output register only changes on an advance, so a stall holds d/bo
            if (s2_adv) begin
                out_valid <= 1'b1;
                d         <= d_nxt;
                bo        <= b[W-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_pipe.sv
// Self-checking bench for sub_pipe (W=6) against an arithmetic reference model and scoreboard.
// Define SUB_SATURATE_EN for both bench and RTL to check the clamping build.
module tb_sub_pipe;

    localparam int unsigned W = 6;

`ifdef SUB_SATURATE_EN
    localparam logic [W-1:0] EXP_3_7  = 6'd0;
    localparam logic [W-1:0] EXP_0_63 = 6'd0;
`else
    localparam logic [W-1:0] EXP_3_7  = 6'd60;
    localparam logic [W-1:0] EXP_0_63 = 6'd1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bo;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    logic [W:0]   exp_q [$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_bo;

    sub_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] c);
        int           diff;
        logic         bor;
        logic [W-1:0] r;
        diff = int'(a) - int'(c);
        bor  = (a < c);
        r    = W'((diff + 64) % 64);
`ifdef SUB_SATURATE_EN
        if (bor) r = '0;
`endif
        return {bor, r};
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer, check stall hold.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_d", d, prev_d);
                check("hold_bo", bo, prev_bo);
            end
            if (out_valid && out_ready) begin
                check("out_has_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("sb_d", d, e[W-1:0]);
                    check("sb_bo", bo, e[W]);
                end
                n_out++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(golden(x, y));
            prev_stall = out_valid && !out_ready;
            prev_d     = d;
            prev_bo    = bo;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic single(input logic [W-1:0] a, input logic [W-1:0] c,
                          input logic [W-1:0] ed, input logic eb, input string tag);
        x = a; y = c; in_valid = 1'b1; out_ready = 1'b1;
        sample();
        check({tag, "_v0"}, out_valid, 0);
        step();
        in_valid = 1'b0;
        sample();
        check({tag, "_v1"}, out_valid, 0);
        step();
        sample();
        check({tag, "_v2"}, out_valid, 1);
        check({tag, "_d"}, d, ed);
        check({tag, "_bo"}, bo, eb);
        step();
    endtask

    // Streams n operand pairs; sequential (x,y) sweep when rnd=0.
    task automatic stream(input int n, input bit rnd, input int vpct, input int rpct,
                          output int cycles);
        int idx;
        bit acc;
        logic [11:0] code;
        idx = 0; cycles = 0; code = '0;
        x = rnd ? W'($urandom) : '0;
        y = rnd ? W'($urandom) : '0;
        in_valid  = ($urandom_range(0, 99) < vpct);
        out_ready = ($urandom_range(0, 99) < rpct);
        while (idx < n && cycles < 20000) begin
            sample();
            acc = in_valid && in_ready;
            step();
            cycles++;
            if (acc) begin
                idx++;
                code = 12'(idx);
                x = rnd ? W'($urandom) : code[11:6];
                y = rnd ? W'($urandom) : code[5:0];
            end
            if (!in_valid || acc)
                in_valid = (idx < n) && ($urandom_range(0, 99) < vpct);
            out_ready = ($urandom_range(0, 99) < rpct);
        end
        in_valid = 1'b0;
        check("stream_count", idx, n);
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
            sample();
        end
        check(tag, exp_q.size(), 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int out0;
        int nacc;
        bit acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
        repeat (2) step();
        rst_n = 1'b1;
        sample();
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 0);
        check("rst_bo", bo, 0);
        check("rst_in_ready", in_ready, 1);
        step();

        single(6'd13, 6'd5,  6'd8,    1'b0, "t1_13_5");
        single(6'd3,  6'd7,  EXP_3_7, 1'b1, "t2_3_7");
        single(6'd0,  6'd0,  6'd0,    1'b0, "eq_0_0");
        single(6'd0,  6'd63, EXP_0_63, 1'b1, "wrap_0_63");

        out0 = n_out;
        stream(16, 1'b1, 100, 100, cyc);
        check("t3_cycles", cyc, 16);
        step();
        sample();
        check("t3_results", n_out - out0, 16);
        drain("t3_drain");

        out0 = n_out; nacc = 0;
        out_ready = 1'b0; in_valid = 1'b1; x = W'($urandom); y = W'($urandom);
        repeat (5) begin
            sample();
            acc = in_ready;
            if (acc) nacc++;
            step();
            if (acc) begin x = W'($urandom); y = W'($urandom); end
        end
        sample();
        check("t4_accepts", nacc, 2);
        check("t4_in_ready", in_ready, 0);
        check("t4_out_valid", out_valid, 1);
        step();
        drain("t4_drain");
        check("t4_results", n_out - out0, 2);

        out_ready = 1'b0; in_valid = 1'b1; x = 6'd40; y = 6'd2;
        repeat (2) step();
        x = 6'd9; y = 6'd33;
        sample();
        check("t5_full", in_ready, 0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sample();
        check("t5_out_valid", out_valid, 0);
        check("t5_d", d, 0);
        check("t5_bo", bo, 0);
        check("t5_in_ready", in_ready, 1);
        repeat (4) begin
            step();
            sample();
            check("t5_no_stale", out_valid, 0);
        end
        step();

        out0 = n_out;
        stream(4096, 1'b0, 80, 70, cyc);
        drain("t6_drain");
        check("t6_results", n_out - out0, 4096);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
